wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback-stage consumer of the MEM/WB pipeline outputs. Selects the writeback result,
//  commits it to the 32x32 integer register file and serves the two decode-stage read ports.
//  Sits between the MEM/WB register and the ID stage. ResultW is also exported to the
//  hazard/forwarding unit.
// PARAMETERS
//  XLEN        32  data width of every register and result
//  NREGS       32  architectural register count; rd/rs width = $clog2(NREGS)
// PORTS
//  clk         in   1     clock, rising-edge
//  rst         in   1     asynchronous reset, active-high
//  ALUResultW  in   XLEN  ALU result from MEM/WB
//  ReadDataW   in   XLEN  load data from MEM/WB
//  PCPlus4W    in   XLEN  link address from MEM/WB
//  rdW         in   5     destination register
//  RegWriteW   in   1     write enable
//  ResultSrcW  in   2     00=ALU, 01=Mem, 10=PC+4, 11=reserved
//  rs1D        in   5     decode read address A
//  rs2D        in   5     decode read address B
//  RD1D        out  XLEN  read data A
//  RD2D        out  XLEN  read data B
//  ResultW     out  XLEN  selected writeback value, to forwarding muxes
//  a0          out  XLEN  live copy of x10, for bench/top-level observation
//  RetireCnt   out  64    committed-write counter (present only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset: rst is asynchronous and active-high. On assertion, x1..x31 clear to 0 immediately,
//    a0 reads 0 and RetireCnt clears to 0. Combinational outputs follow their inputs.
//  - Result select (combinational): 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W.
//    11 -> ALUResultW (reserved encoding, defined as ALU; no X propagation).
//  - Write: at posedge clk, when RegWriteW=1 and rdW!=0, regs[rdW] <= ResultW.
//    A write to x0 is discarded, and x0 always reads 0.
//  - Read: combinational, RDnD = (rsnD==0) ? 0 : regs[rsnD].
//  - Same-cycle bypass: if RegWriteW=1, rdW!=0 and rsnD==rdW, then RDnD = ResultW
//    (write-through). The ID stage therefore sees the value being written this cycle,
//    which removes the WB->ID hazard. Both ports may bypass simultaneously.
//  - Latency: a write becomes visible combinationally in the same cycle via the bypass,
//    and becomes visible from the array on the next cycle.
//  - a0 = regs[10] (array value, not bypassed).
//  - If rst is asserted while a write is pending, reset wins and no write occurs that edge.
//    After release, the first edge writes normally.
//  - There are no stalls. Every cycle's W-stage contents are consumed exactly once;
//    bubbles arrive as RegWriteW=0.
// CONFIGURATION
//  `WB_RETIRE_CNT_EN defined:
//   - RetireCnt is a 64-bit counter, +1 on every edge with RegWriteW=1 and rdW!=0.
//   - It wraps from 2^64-1 to 0 and is cleared by rst.
//  `WB_RETIRE_CNT_EN undefined: the RetireCnt port and counter are absent; all other
//   behaviour is identical.
// STRUCTURE
//  - wb_pkg: localparams RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSV=2'b11,
//    plus XLEN and REG_ADDR_W.
//  - One sub-module, regfile_2r1w: storage, x0 hardwiring and write-through bypass.
//  - The top module holds the result mux, the a0 tap and the optional counter.
// TESTING
//  1. Hold rst=1 after random writes -> every RDnD=0, a0=0, RetireCnt=0.
//  2. rdW=5, RegWriteW=1, ResultSrcW=00, ALUResultW=0x1234, rs1D=5 in the same cycle
//     -> RD1D=0x1234 (bypass) and ResultW=0x1234. Next cycle, with RegWriteW=0, RD1D=0x1234.
//  3. rdW=0, RegWriteW=1, ALUResultW=0xFFFFFFFF -> rs1D=0 and rs2D=0 both read 0 now and
//     next cycle; RetireCnt unchanged.
//  4. Sweep ResultSrcW 00/01/10/11 with ALU=0xA, Mem=0xB, PC4=0xC
//     -> ResultW = 0xA, 0xB, 0xC, 0xA respectively.
//  5. Write x10=0xDEADBEEF via ResultSrcW=01 -> a0=0xDEADBEEF the following cycle;
//     rs1D=rs2D=10 in the write cycle gives both ports 0xDEADBEEF.
//  6. RegWriteW=1, rdW=3, with rst pulsed asynchronously mid-cycle -> x3 stays 0 after the
//     edge. With WB_RETIRE_CNT_EN, 7 later valid writes -> RetireCnt=7.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: data width, register-address
// width and the ResultSrcW encodings used by the writeback result mux.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  // ResultSrcW encodings. RES_RSV is reserved and behaves like RES_ALU.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_RSV = 2'b11;

  // Architectural index of a0 (x10), tapped for top-level observation.
  localparam int A0_IDX = 10;

  // Writeback result selection. The reserved encoding falls back to the ALU
  // result so the output never carries X.
  function automatic logic [XLEN-1:0] select_result(
    input logic [1:0]      src,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] pc4
  );
    logic [XLEN-1:0] res;
    case (src)
      RES_MEM: res = mem;
      RES_PC4: res = pc4;
      default: res = alu;
    endcase
    return res;
  endfunction

endpackage : wb_pkg

// File: rtl/regfile_2r1w.sv
// Two-read / one-write integer register file.
// - x0 is hardwired to zero: it has no storage and writes to it are dropped.
// - Reads are combinational with write-through bypass, so a value being
//   written this cycle is already visible on a read port addressing it.
// - A third, non-bypassed tap port exposes the raw array contents.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [AW-1:0]   taddr,
  output logic [XLEN-1:0] tdata
);

  // Storage starts at x1; x0 has no flops at all.
  logic [XLEN-1:0] regs [1:NREGS-1];

  logic wr_valid;
  logic hit1;
  logic hit2;

  assign wr_valid = we && (waddr != '0);
  assign hit1     = wr_valid && (raddr1 == waddr);
  assign hit2     = wr_valid && (raddr2 == waddr);

  // Array update: asynchronous clear, then one committed write per edge.
  // NOTE: every register of the array is reset here because the architecture
  // requires x1..x31 to read zero immediately on reset; a plain RAM without
  // this requirement should be left unreset so it can map to memory macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      regs[waddr] <= wdata;
    end
  end

  // Read port A: x0 reads zero, a matching in-flight write is bypassed.
  always_comb begin
    // NOTE: defaulting the output first guarantees every path assigns it,
    // so no latch is inferred for the unaddressed cases.
    rdata1 = '0;
    if (raddr1 != '0) begin
      rdata1 = hit1 ? wdata : regs[raddr1];
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      rdata2 = hit2 ? wdata : regs[raddr2];
    end
  end

  // Observation tap: raw array value, deliberately not bypassed.
  always_comb begin
    tdata = '0;
    if (taddr != '0) begin
      tdata = regs[taddr];
    end
  end

endmodule : regfile_2r1w

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result from the MEM/WB outputs, commits it to
// the register file and serves the two decode-stage read ports. ResultW is
// also exported for the forwarding muxes.
// Optional build macro: WB_RETIRE_CNT_EN adds a 64-bit committed-write
// counter on the RetireCnt port; without it the port and counter are absent.
module wb_regfile #(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int NREGS = wb_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [AW-1:0]   rdW,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [AW-1:0]   rs1D,
  input  logic [AW-1:0]   rs2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] a0
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     RetireCnt
`endif
);

  import wb_pkg::*;

  localparam logic [AW-1:0] A0_ADDR = AW'(A0_IDX);

  // Writeback result mux; reserved encoding resolves to the ALU result.
  always_comb begin
    ResultW = ALUResultW;
    case (ResultSrcW)
      RES_ALU: ResultW = ALUResultW;
      RES_MEM: ResultW = ReadDataW;
      RES_PC4: ResultW = PCPlus4W;
      RES_RSV: ResultW = ALUResultW;
      default: ResultW = ALUResultW;
    endcase
  end

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWriteW),
    .waddr  (rdW),
    .wdata  (ResultW),
    .raddr1 (rs1D),
    .raddr2 (rs2D),
    .rdata1 (RD1D),
    .rdata2 (RD2D),
    .taddr  (A0_ADDR),
    .tdata  (a0)
  );

`ifdef WB_RETIRE_CNT_EN
  // Count committed writes (x0 writes are not commits); wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RetireCnt <= '0;
    end else if (RegWriteW && (rdW != '0)) begin
      RetireCnt <= RetireCnt + 64'd1;
    end
  end
`endif

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the stimulus process predicts each
// cycle's outputs from an architectural model and queues them; a monitor
// compares the DUT outputs against the queue at every falling edge.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  rdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
  logic [31:0] a0;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] RetireCnt;
`endif

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .rdW        (rdW),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW),
    .a0         (a0)
`ifdef WB_RETIRE_CNT_EN
    ,
    .RetireCnt  (RetireCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] res;
    logic [31:0] a0;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  logic [63:0] cnt_model;
  int          n_vec;
  int          n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cnt_model = 64'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] rs, input logic we,
                                             input logic [4:0] rd, input logic [31:0] res);
    if (rs == 5'd0) return 32'h0;
    if (we && rd != 5'd0 && rs == rd) return res;
    return model[rs];
  endfunction

  // Drive one W-stage cycle (called just after a rising edge), queue the
  // predicted outputs, then retire the write into the model at the next edge.
  task automatic apply(input string tag, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic we, input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t        e;
    logic [31:0] res;
    ResultSrcW = src;
    ALUResultW = alu;
    ReadDataW  = mem;
    PCPlus4W   = pc4;
    rdW        = rd;
    RegWriteW  = we;
    rs1D       = rs1;
    rs2D       = rs2;
    res   = (src == 2'd1) ? mem : (src == 2'd2) ? pc4 : alu;
    e.tag = tag;
    e.res = res;
    e.rd1 = model_read(rs1, we, rd, res);
    e.rd2 = model_read(rs2, we, rd, res);
    e.a0  = model[10];
    e.cnt = cnt_model;
    sb.push_back(e);
    @(posedge clk);
    if (!rst && we && rd != 5'd0) begin
      model[rd] = res;
      cnt_model = cnt_model + 64'd1;
    end
    #1;
  endtask

  task automatic rand_cycle(input string tag, input logic we_force_off);
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       we;
    rd  = 5'($urandom_range(0, 31));
    we  = we_force_off ? 1'b0 : 1'($urandom_range(0, 1));
    rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
    rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
    apply(tag, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, rd, we, rs1, rs2);
  endtask

  // Monitor: one comparison set per queued cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, "/RD1D"},    64'(RD1D),    64'(e.rd1));
        check({e.tag, "/RD2D"},    64'(RD2D),    64'(e.rd2));
        check({e.tag, "/ResultW"}, 64'(ResultW), 64'(e.res));
        check({e.tag, "/a0"},      64'(a0),      64'(e.a0));
`ifdef WB_RETIRE_CNT_EN
        check({e.tag, "/RetireCnt"}, RetireCnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst = 1'b1;
    ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0;
    rdW = '0; RegWriteW = 1'b0; ResultSrcW = '0; rs1D = '0; rs2D = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Random writes, then reset held: everything must read zero.
    for (int i = 0; i < 40; i++) rand_cycle("prefill", 1'b0);
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) rand_cycle("rst_hold", 1'b1);
    rst = 1'b0;

    // Same-cycle bypass, then array read on the following cycle.
    apply("bypass_x5", 2'd0, 32'h1234, $urandom, $urandom, 5'd5, 1'b1, 5'd5, 5'd0);
    apply("after_x5",  2'd0, $urandom, $urandom, $urandom, 5'd0, 1'b0, 5'd5, 5'd5);

    // Write to x0 is discarded now and next cycle.
    apply("x0_write", 2'd0, 32'hFFFF_FFFF, $urandom, $urandom, 5'd0, 1'b1, 5'd0, 5'd0);
    apply("x0_next",  2'd0, $urandom, $urandom, $urandom, 5'd0, 1'b0, 5'd0, 5'd0);

    // Result select sweep including the reserved encoding.
    for (int s = 0; s < 4; s++)
      apply($sformatf("src_%0d", s), 2'(s), 32'hA, 32'hB, 32'hC, 5'd0, 1'b0, 5'd5, 5'd0);

    // a0 tap: both ports bypass in the write cycle, a0 updates next cycle.
    apply("a0_write", 2'd1, $urandom, 32'hDEAD_BEEF, $urandom, 5'd10, 1'b1, 5'd10, 5'd10);
    apply("a0_next",  2'd0, $urandom, $urandom, $urandom, 5'd0, 1'b0, 5'd10, 5'd31);

    // Reset asserted mid-cycle during a pending write to x3: reset wins.
    ResultSrcW = 2'd0; ALUResultW = 32'h3333_3333; rdW = 5'd3; RegWriteW = 1'b1;
    rs1D = 5'd0; rs2D = 5'd0;
    #2;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #2;
    rst = 1'b0;
    apply("x3_after_rst", 2'd0, $urandom, $urandom, $urandom, 5'd0, 1'b0, 5'd3, 5'd10);

    // First edge after release writes normally; seven committed writes.
    for (int i = 1; i <= 7; i++)
      apply($sformatf("post_rst_wr%0d", i), 2'd2, $urandom, $urandom, 32'h100 + 32'(i),
            5'(i), 1'b1, 5'(i), 5'd3);
    apply("post_rst_rd", 2'd0, $urandom, $urandom, $urandom, 5'd0, 1'b0, 5'd1, 5'd7);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) rand_cycle("random", 1'b0);

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_wb_regfile
